// File: rtl/pearson_pkg.sv
// Shared types and the default Pearson permutation table for the streaming hash engine.
// The table is generated from a bijective byte map, so every entry is a permutation of 0..255.
package pearson_pkg;

  typedef logic [7:0] lane_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef logic [255:0][7:0] tbl_t;

  // Odd multiply plus offset is a bijection mod 256; rotate and xor keep it one.
  function automatic lane_t perm_entry(input int x);
    lane_t v;
    v = 8'(x * 167 + 13);
    return {v[4:0], v[7:5]} ^ 8'h5A;
  endfunction

  function automatic tbl_t gen_table();
    tbl_t t;
    for (int x = 0; x < 256; x++) t[8'(x)] = perm_entry(x);
    return t;
  endfunction

  localparam tbl_t PEARSON_T = gen_table();

endpackage

// File: rtl/pearson_hash_stream_if.sv
// Byte-in / digest-out handshake bundle for pearson_hash_stream.
// master = producer/consumer side, slave = hash engine.
interface pearson_hash_stream_if #(
  parameter int LANES   = 4,
  parameter int MAX_LEN = 80
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_byte;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_hash;
  logic [LW-1:0]      out_len;
  logic               out_err;

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_hash, out_len, out_err
  );

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_hash, out_len, out_err
  );
endinterface

// File: rtl/pearson_lane.sv
// One Pearson lane: forms the table index (seed or running hash, xor byte) and
// registers the looked-up entry on every accepted byte. Table read lives in the top.
module pearson_lane
  import pearson_pkg::*;
#(
  parameter int LANE_ID = 0
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  i_acc,
  input  logic  i_first,
  input  lane_t i_byte,
  input  lane_t i_tval,
  output lane_t o_idx,
  output lane_t o_h
);
  localparam lane_t SEED = lane_t'(LANE_ID);

  lane_t r_h;

  // First byte of a message is keyed by the lane number, not the stale hash.
  assign o_idx = (i_first ? SEED : r_h) ^ i_byte;
  assign o_h   = r_h;

  always_ff @(posedge clk) begin
    if (!reset_n)   r_h <= '0;
    else if (i_acc) r_h <= i_tval;
  end
endmodule

// File: rtl/pearson_hash_stream.sv
// Streaming multi-lane Pearson hash: one byte/cycle in, 8*LANES-bit digest out the cycle after the last byte.
// PEARSON_TBL_WR_EN: table becomes a writable register array (writes honoured only in IDLE).
module pearson_hash_stream
  import pearson_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int MAX_LEN = 80
) (
  input  logic                        clk,
  input  logic                        reset_n,
  pearson_hash_stream_if.slave        bus
`ifdef PEARSON_TBL_WR_EN
  ,
  input  logic                        tbl_we,
  input  logic [7:0]                  tbl_addr,
  input  logic [7:0]                  tbl_data
`endif
);
  localparam int LW = $clog2(MAX_LEN + 1);

  state_e            r_state;
  logic [LW-1:0]     r_len;
  logic              r_err;
  logic              w_acc;
  logic              w_first;
  logic              w_done;
  logic [8*LANES-1:0] w_hash;
  lane_t             w_idx  [LANES];
  lane_t             w_tval [LANES];
  lane_t             w_h    [LANES];

  assign w_done       = (r_state == ST_DONE);
  assign w_first      = (r_state == ST_IDLE);
  assign bus.in_ready = ~w_done;
  assign w_acc        = bus.in_valid & ~w_done;

`ifdef PEARSON_TBL_WR_EN
  lane_t r_tbl [256];

  // Registered table: a same-cycle write and lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 256; k++) r_tbl[8'(k)] <= PEARSON_T[8'(k)];
    end else if (tbl_we && w_first) begin
      r_tbl[tbl_addr] <= tbl_data;
    end
  end
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef PEARSON_TBL_WR_EN
    assign w_tval[g] = r_tbl[w_idx[g]];
`else
    assign w_tval[g] = PEARSON_T[w_idx[g]];
`endif
    assign w_hash[8*g +: 8] = w_h[g];

    pearson_lane #(.LANE_ID(g)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .i_acc   (w_acc),
      .i_first (w_first),
      .i_byte  (bus.in_byte),
      .i_tval  (w_tval[g]),
      .o_idx   (w_idx[g]),
      .o_h     (w_h[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_acc) begin
          r_len   <= LW'(1);
          r_err   <= 1'b0;
          r_state <= bus.in_last ? ST_DONE : ST_ABSORB;
        end
        ST_ABSORB: if (w_acc) begin
          // Saturate the count and latch the overflow; the hash keeps absorbing.
          if (r_len == LW'(MAX_LEN)) r_err <= 1'b1;
          else                       r_len <= r_len + LW'(1);
          if (bus.in_last) r_state <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = w_done;
  assign bus.out_hash  = w_done ? w_hash : '0;
  assign bus.out_len   = w_done ? r_len  : '0;
  assign bus.out_err   = w_done & r_err;
endmodule

// File: tb/tb_pearson_hash_stream.sv
// Directed-plus-random bench for pearson_hash_stream against a plain Pearson reference model.
// With PEARSON_TBL_WR_EN defined it also exercises table loading and ABSORB-time write blocking.
module tb_pearson_hash_stream;
  import pearson_pkg::*;

  localparam int LANES   = 4;
  localparam int MAX_LEN = 80;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pearson_hash_stream_if #(.LANES(LANES), .MAX_LEN(MAX_LEN)) bus ();

`ifdef PEARSON_TBL_WR_EN
  logic       tbl_we = 1'b0;
  logic [7:0] tbl_addr = '0;
  logic [7:0] tbl_data = '0;
  logic [7:0] ref_tbl [256];
`endif

  pearson_hash_stream #(.LANES(LANES), .MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus)
`ifdef PEARSON_TBL_WR_EN
    ,
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data)
`endif
  );

  function automatic logic [7:0] tval(input logic [7:0] x);
`ifdef PEARSON_TBL_WR_EN
    return ref_tbl[x];
`else
    return PEARSON_T[x];
`endif
  endfunction

  // Classic Pearson hash per lane, lane number used as the seed byte.
  function automatic logic [8*LANES-1:0] ref_hash(input logic [7:0] m [$]);
    logic [8*LANES-1:0] r;
    logic [7:0] h;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      h = tval(8'(l) ^ m[0]);
      for (int k = 1; k < m.size(); k++) h = tval(h ^ m[k]);
      r[8*l +: 8] = h;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] m [$], input bit gaps);
    int idx;
    int guard;
    bit bub;
    idx = 0;
    guard = 0;
    bub = gaps;
    while (idx < m.size() && guard < 4 * m.size() + 20) begin
      @(negedge clk);
      guard++;
      if (bub) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bub = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_byte  = m[idx];
        bus.in_last  = (idx == m.size() - 1);
        if (bus.in_ready) idx++;
        bub = gaps;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("send.progress", 64'(idx), 64'(m.size()));
  endtask

  // Handoff cycle also offers a junk byte, which must not be absorbed.
  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_byte   = 8'hC3;
    bus.in_last   = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    check({tag, ".post_vld"},  64'(bus.out_valid), 64'(0));
    check({tag, ".post_rdy"},  64'(bus.in_ready),  64'(1));
    check({tag, ".post_hash"}, 64'(bus.out_hash),  64'(0));
    check({tag, ".post_len"},  64'(bus.out_len),   64'(0));
  endtask

  task automatic run_msg(input string tag, input logic [7:0] m [$], input bit gaps,
                         output logic [8*LANES-1:0] got);
    int exp_len;
    exp_len = (m.size() > MAX_LEN) ? MAX_LEN : m.size();
    send(m, gaps);
    got = bus.out_hash;
    check({tag, ".vld"},  64'(bus.out_valid), 64'(1));
    check({tag, ".hash"}, 64'(bus.out_hash),  64'(ref_hash(m)));
    check({tag, ".len"},  64'(bus.out_len),   64'(exp_len));
    check({tag, ".err"},  64'(bus.out_err),   64'(m.size() > MAX_LEN));
    consume(tag);
  endtask

  initial begin
    logic [7:0] m [$];
    logic [8*LANES-1:0] h1, h2, hx;
    int n;

    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef PEARSON_TBL_WR_EN
    for (int a = 0; a < 256; a++) ref_tbl[a] = PEARSON_T[8'(a)];
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst.rdy",  64'(bus.in_ready),  64'(1));
    check("rst.vld",  64'(bus.out_valid), 64'(0));
    check("rst.hash", 64'(bus.out_hash),  64'(0));
    check("rst.len",  64'(bus.out_len),   64'(0));
    check("rst.err",  64'(bus.out_err),   64'(0));

    m = '{8'h00};
    run_msg("zero", m, 1'b0, hx);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 20);
      m = {};
      for (int k = 0; k < n; k++) m.push_back(8'($urandom));
      run_msg("rand", m, 1'($urandom_range(0, 1)), hx);
    end

    // Digest held with consumer stalled; offered bytes must be refused.
    m = '{8'h5A, 8'h01, 8'hFF};
    send(m, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("bp.rdy",  64'(bus.in_ready),  64'(0));
      check("bp.vld",  64'(bus.out_valid), 64'(1));
      check("bp.hash", 64'(bus.out_hash),  64'(ref_hash(m)));
      check("bp.len",  64'(bus.out_len),   64'(3));
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'($urandom);
      bus.in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    consume("bp");
    m = '{8'h77, 8'h10};
    run_msg("bp.next", m, 1'b0, hx);

    m = {};
    for (int k = 0; k < 10; k++) m.push_back(8'($urandom));
    run_msg("nogap", m, 1'b0, h1);
    run_msg("gap",   m, 1'b1, h2);
    check("gap.same", 64'(h2), 64'(h1));

    m = {};
    for (int k = 0; k < MAX_LEN + 2; k++) m.push_back(8'($urandom));
    run_msg("ovf", m, 1'b0, hx);
    m = '{8'h01, 8'h02, 8'h03};
    run_msg("ovf.next", m, 1'b0, hx);

    // Reset lands mid-message; the partial bytes must be forgotten.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_byte = 8'h11; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_byte = 8'h22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mrst.rdy",  64'(bus.in_ready),  64'(1));
    check("mrst.vld",  64'(bus.out_valid), 64'(0));
    check("mrst.hash", 64'(bus.out_hash),  64'(0));
    m = '{8'hAB};
    run_msg("mrst.msg", m, 1'b0, hx);

`ifdef PEARSON_TBL_WR_EN
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = 8'(a); tbl_data = 8'(a);
      ref_tbl[a] = 8'(a);
    end
    @(negedge clk);
    tbl_we = 1'b0;
    m = '{8'h12, 8'h34, 8'h56};
    run_msg("ident", m, 1'b0, hx);
    check("ident.gold", 64'(hx), 64'(32'h7372_7170));

    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_byte = 8'h01; bus.in_last = 1'b0;
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 8'h05; tbl_data = 8'hEE;
    bus.in_byte = 8'h02; bus.in_last = 1'b1;
    @(negedge clk);
    tbl_we = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("absw.vld", 64'(bus.out_valid), 64'(1));
    consume("absw");
    m = '{8'h05};
    run_msg("absw.read", m, 1'b0, hx);
    check("absw.lane0", 64'(hx[7:0]), 64'(8'h05));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
